// File: rtl/vram_scan_arbiter_pkg.sv
// Shared video timing constants and grant-state encoding for the framebuffer arbiter.
package vram_scan_arbiter_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } grant_e;

endpackage

// File: rtl/vram_scan_arbiter_scan_addr.sv
// Scan-out read address counter: increments per fetch, resyncs at frame origin, wraps at frame
// end, and pulses frame_done one cycle after the last visible pixel's read is issued.
module vram_scan_arbiter_scan_addr #(
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned FRAME_PIXELS = 307200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              resync,
  output logic [ADDR_W-1:0] addr,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic              last_q;

  // Address used by the current fetch; the frame origin always reads address 0.
  always_comb begin
    addr = resync ? '0 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      last_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      last_q     <= en && (addr == LAST);
      frame_done <= last_q;
      if (en) begin
        cnt_q <= (addr == LAST) ? '0 : addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM arbiter: scan-out fetch has absolute priority, the req/ack pixel writer
// is served in free cycles. All outputs registered; pixel appears two cycles after its read.
module vram_scan_arbiter #(
  parameter int unsigned H_ACTIVE = vram_scan_arbiter_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = vram_scan_arbiter_pkg::V_ACTIVE,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              activeVideo,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              frame_done
);

  import vram_scan_arbiter_pkg::*;

  localparam int unsigned     FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam logic [9:0]      H_LIM        = 10'(H_ACTIVE);
  localparam logic [9:0]      V_LIM        = 10'(V_ACTIVE);
  localparam logic [ADDR_W:0] FRAME_LIM    = (ADDR_W + 1)'(FRAME_PIXELS);

  logic              slot;
  logic              resync;
  logic              wr_in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_v1;
  grant_e            state_q;

  // activeVideo alone is not trusted to bound the visible window.
  assign slot        = activeVideo && (x < H_LIM) && (y < V_LIM);
  assign resync      = slot && (x == 10'd0) && (y == 10'd0);
  assign wr_in_range = {1'b0, wr_addr} < FRAME_LIM;

  vram_scan_arbiter_scan_addr #(
    .ADDR_W       (ADDR_W),
    .FRAME_PIXELS (FRAME_PIXELS)
  ) u_scan_addr (
    .clk        (clk),
    .rst        (rst),
    .en         (slot),
    .resync     (resync),
    .addr       (rd_addr),
    .frame_done (frame_done)
  );

  // The request is consumed at the edge that raises wr_ack; the writer must retire or
  // replace it before the following edge, which allows one write per free cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      rd_v1     <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      rd_v1     <= (state_q == S_READ);
      pix_valid <= rd_v1;
      pix_data  <= rd_v1 ? mem_rdata : '0;
      if (slot) begin
        state_q  <= S_READ;
        mem_addr <= rd_addr;
      end else if (wr_req) begin
        state_q <= S_WRITE;
        wr_ack  <= 1'b1;
        if (wr_in_range) begin
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
          mem_we    <= 1'b1;
        end else begin
          wr_err <= 1'b1;
        end
      end else begin
        state_q <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench: full-size arbiter for scan/contention/write checks, a 6x3 instance for
// frame wrap and frame_done timing.
module tb_vram_scan_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Full-size instance
  logic [9:0]  x, y;
  logic        av, wr_req;
  logic [18:0] wr_addr, mem_addr;
  logic [7:0]  wr_data, mem_wdata, mem_rdata, pix_data;
  logic        wr_ack, wr_err, mem_we, pix_valid, frame_done;

  vram_scan_arbiter u_dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .activeVideo(av), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .frame_done(frame_done)
  );

  // Small 6x3 instance (18 pixels, not a power of two)
  logic [9:0] sx, sy;
  logic       sav;
  logic       s_wr_req = 1'b0;
  logic [4:0] s_wr_addr = 5'd0;
  logic [7:0] s_wr_data = 8'd0;
  logic [4:0] s_mem_addr;
  logic [7:0] s_mem_wdata, s_mem_rdata, s_pix_data;
  logic       s_wr_ack, s_wr_err, s_mem_we, s_pix_valid, s_frame_done;

  vram_scan_arbiter #(.H_ACTIVE(6), .V_ACTIVE(3), .ADDR_W(5), .DATA_W(8)) u_small (
    .clk(clk), .rst(rst), .x(sx), .y(sy), .activeVideo(sav), .wr_req(s_wr_req),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_ack(s_wr_ack), .wr_err(s_wr_err),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we),
    .mem_rdata(s_mem_rdata), .pix_data(s_pix_data), .pix_valid(s_pix_valid),
    .frame_done(s_frame_done)
  );

  // RAM models, preloaded on the first edge: big RAM holds addr[7:0], small holds 0x40+addr.
  logic [7:0] ram [0:(1<<19)-1];
  logic [7:0] sram [0:31];
  logic       loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < (1 << 19); i++) ram[i] <= i[7:0];
      for (int i = 0; i < 32; i++) sram[i] <= 8'h40 + i[7:0];
      loaded <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (s_mem_we) sram[s_mem_addr] <= s_mem_wdata;
    end
    mem_rdata   <= ram[mem_addr];
    s_mem_rdata <= sram[s_mem_addr];
  end

  int checks = 0;
  int passed = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; av = 1'b0; x = 10'd700; y = 10'd0;
    sav = 1'b0; sx = 10'd0; sy = 10'd0;
    wr_req = 1'b1; wr_addr = 19'd300000; wr_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({wr_ack, wr_err, mem_we, pix_valid, frame_done, mem_addr, mem_wdata, pix_data} !== '0)
        $display("FAIL reset_outputs[%0d]: ack=%b err=%b we=%b pv=%b fd=%b addr=%0d wd=%0h pd=%0h, want all 0",
                 i, wr_ack, wr_err, mem_we, pix_valid, frame_done, mem_addr, mem_wdata, pix_data);
      else passed++;
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({wr_ack, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 19'd300000, 8'h55})
      $display("FAIL reset_release_write: ack=%b we=%b addr=%0d wd=%0h, want 1 1 300000 55",
               wr_ack, mem_we, mem_addr, mem_wdata);
    else passed++;
    wr_req = 1'b0;
    tick;
    checks++;
    if ({wr_ack, mem_we} !== 2'b00)
      $display("FAIL reset_release_single: ack=%b we=%b, want 0 0", wr_ack, mem_we);
    else passed++;
  endtask

  task automatic test_scan;
    for (int ln = 0; ln < 2; ln++) begin
      for (int k = 0; k < ((ln == 0) ? 800 : 3); k++) begin
        x = 10'(k); y = 10'(ln); av = (k < 640);
        tick;
        if (ln == 0 && k == 5) begin
          checks++;
          if ({mem_addr, mem_we} !== {19'd5, 1'b0})
            $display("FAIL scan_addr_x5: addr=%0d we=%b, want 5 0", mem_addr, mem_we);
          else passed++;
        end
        if (ln == 0 && k == 7) begin
          checks++;
          if ({pix_valid, pix_data} !== {1'b1, 8'd5})
            $display("FAIL scan_pix_x5: pv=%b pd=%0d, want 1 5", pix_valid, pix_data);
          else passed++;
        end
        if (ln == 0 && k == 642) begin
          checks++;
          if ({pix_valid, pix_data} !== 9'd0)
            $display("FAIL scan_pix_blank: pv=%b pd=%0d, want 0 0", pix_valid, pix_data);
          else passed++;
        end
        if (ln == 1 && k == 0) begin
          checks++;
          if (mem_addr !== 19'd640)
            $display("FAIL scan_addr_line1: addr=%0d, want 640", mem_addr);
          else passed++;
        end
        if (ln == 1 && k == 2) begin
          checks++;
          if ({pix_valid, pix_data} !== {1'b1, 8'd128})
            $display("FAIL scan_pix_line1: pv=%b pd=%0d, want 1 128", pix_valid, pix_data);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_contention;
    bit early_ack = 1'b0;
    y = 10'd2;
    for (int k = 0; k <= 640; k++) begin
      x = 10'(k); av = (k < 640);
      if (k == 300) begin
        wr_req = 1'b1; wr_addr = 19'd100; wr_data = 8'hAA;
      end
      tick;
      if (k >= 300 && k < 640 && (wr_ack || mem_we)) early_ack = 1'b1;
    end
    checks++;
    if (early_ack) $display("FAIL contention_no_ack: ack/we seen during slot, want none");
    else passed++;
    checks++;
    if ({wr_ack, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 19'd100, 8'hAA})
      $display("FAIL contention_grant: ack=%b we=%b addr=%0d wd=%0h, want 1 1 100 aa",
               wr_ack, mem_we, mem_addr, mem_wdata);
    else passed++;
    wr_req = 1'b0; x = 10'd641;
    tick;
    checks++;
    if (ram[100] !== 8'hAA) $display("FAIL contention_readback: ram[100]=%0h, want aa", ram[100]);
    else passed++;
  endtask

  task automatic test_back_to_back;
    // activeVideo deliberately high in blanking: must not steal cycles
    x = 10'd700; y = 10'd2; av = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = 19'(200 + i); wr_data = 8'h10 + 8'(i);
      tick;
      checks++;
      if ({wr_ack, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 19'(200 + i), 8'h10 + 8'(i)})
        $display("FAIL b2b_write[%0d]: ack=%b we=%b addr=%0d wd=%0h, want 1 1 %0d %0h",
                 i, wr_ack, mem_we, mem_addr, mem_wdata, 200 + i, 8'h10 + 8'(i));
      else passed++;
    end
    wr_req = 1'b0;
    tick;
    checks++;
    if ({wr_ack, mem_we} !== 2'b00) $display("FAIL b2b_stop: ack=%b we=%b, want 0 0", wr_ack, mem_we);
    else passed++;
  endtask

  task automatic test_range;
    x = 10'd10; y = 10'd480; av = 1'b1;
    wr_req = 1'b1; wr_addr = 19'd307200; wr_data = 8'h33;
    tick;
    checks++;
    if ({wr_ack, wr_err, mem_we} !== 3'b110)
      $display("FAIL range_oob: ack=%b err=%b we=%b, want 1 1 0", wr_ack, wr_err, mem_we);
    else passed++;
    wr_addr = 19'd307199; wr_data = 8'h77;
    tick;
    checks++;
    if ({wr_ack, wr_err, mem_we, mem_addr} !== {3'b101, 19'd307199})
      $display("FAIL range_last: ack=%b err=%b we=%b addr=%0d, want 1 0 1 307199",
               wr_ack, wr_err, mem_we, mem_addr);
    else passed++;
    wr_req = 1'b0;
    tick;
    checks++;
    if ({wr_ack, wr_err, mem_we, mem_addr} !== {3'b000, 19'd307199})
      $display("FAIL idle_hold: ack=%b err=%b we=%b addr=%0d, want 0 0 0 307199",
               wr_ack, wr_err, mem_we, mem_addr);
    else passed++;
    av = 1'b0;
  endtask

  task automatic test_frame_wrap;
    int fd_count = 0;
    // a few mid-frame reads so the counter is nonzero before the frame origin
    sy = 10'd1; sav = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sx = 10'(k);
      tick;
    end
    checks++;
    if (s_mem_addr !== 5'd2) $display("FAIL frame_pre: addr=%0d, want 2", s_mem_addr);
    else passed++;
    for (int yy = 0; yy < 5; yy++) begin
      for (int xx = 0; xx < 10; xx++) begin
        sx = 10'(xx); sy = 10'(yy); sav = (xx < 6);
        tick;
        if (s_frame_done) fd_count++;
        if (yy == 0 && xx == 0) begin
          checks++;
          if (s_mem_addr !== 5'd0) $display("FAIL frame_resync: addr=%0d, want 0", s_mem_addr);
          else passed++;
        end
        if (yy == 0 && xx == 2) begin
          checks++;
          if ({s_pix_valid, s_pix_data} !== {1'b1, 8'h40})
            $display("FAIL frame_pix0: pv=%b pd=%0h, want 1 40", s_pix_valid, s_pix_data);
          else passed++;
        end
        if (yy == 2 && xx == 5) begin
          checks++;
          if ({s_mem_addr, s_frame_done} !== {5'd17, 1'b0})
            $display("FAIL frame_last_read: addr=%0d fd=%b, want 17 0", s_mem_addr, s_frame_done);
          else passed++;
        end
        if (yy == 2 && xx == 6) begin
          checks++;
          if (s_frame_done !== 1'b1) $display("FAIL frame_done_pulse: fd=%b, want 1", s_frame_done);
          else passed++;
        end
      end
    end
    checks++;
    if (fd_count != 1) $display("FAIL frame_done_count: got %0d, want 1", fd_count);
    else passed++;
    sx = 10'd1; sy = 10'd0; sav = 1'b1;
    tick;
    checks++;
    if (s_mem_addr !== 5'd0) $display("FAIL frame_wrap: addr=%0d, want 0", s_mem_addr);
    else passed++;
    sx = 10'd0;
    tick;
    checks++;
    if (s_mem_addr !== 5'd0) $display("FAIL frame_next_origin: addr=%0d, want 0", s_mem_addr);
    else passed++;
    sx = 10'd1;
    tick;
    checks++;
    if (s_mem_addr !== 5'd1) $display("FAIL frame_next_x1: addr=%0d, want 1", s_mem_addr);
    else passed++;
    sav = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_scan;
    test_contention;
    test_back_to_back;
    test_range;
    test_frame_wrap;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vram_scan_arbiter.md
Name: vram_scan_arbiter

Overview:
- Shares one single-port synchronous video RAM between two users: VGA scan-out pixel fetch and a pixel writer (drawing engine or CPU) using a req/ack handshake.
- Sits between the sync generator (x, y, activeVideo) and the framebuffer RAM.
- Scan-out has absolute priority. The writer is served only in cycles with no display fetch.
- Also flags out-of-range writes and marks the end of each scanned frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  pixel clock, shared with the sync generator.
- rst  in  1  synchronous, active-low reset.
- x  in  10  current horizontal count from the sync generator.
- y  in  10  current vertical count from the sync generator.
- activeVideo  in  1  display-enable from the sync generator.
- wr_req  in  1  writer request (level).
- wr_addr  in  ADDR_W  linear pixel address, y*H_ACTIVE+x.
- wr_data  in  DATA_W  pixel value to write.
- wr_ack  out  1  one-cycle pulse: request consumed.
- wr_err  out  1  one-cycle pulse with wr_ack when wr_addr >= H_ACTIVE*V_ACTIVE.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data; valid 1 cycle after address.
- pix_data  out  DATA_W  pixel to DAC; 0 when not valid.
- pix_valid  out  1  pix_data holds a fetched pixel.
- frame_done  out  1  one-cycle pulse after the last visible pixel is fetched.

Behaviour:
- Reset (rst==0 at posedge): all outputs 0, read address counter 0, grant state S_IDLE. wr_req is ignored during reset; a request still held after reset release is served normally.
- Display slot: slot = activeVideo && x<H_ACTIVE && y<V_ACTIVE. activeVideo alone is not trusted for the visible window.
- Grant FSM, re-evaluated every cycle; all outputs are registered.
  - S_READ when slot.
  - else S_WRITE when wr_req.
  - else S_IDLE.
  - Any state may follow any state.
- S_READ: mem_addr=rd_cnt, mem_we=0, then rd_cnt increments.
  - rd_cnt is forced to 0 when a slot cycle has x==0 && y==0 (frame resync); that pixel is read at address 0.
  - rd_cnt wraps to 0 after address H_ACTIVE*V_ACTIVE-1.
- Read pipeline:
  - Read issued in cycle t; mem_rdata captured at end of t+1.
  - pix_data/pix_valid are presented in cycle t+2: fixed 2-cycle latency from slot to pixel.
  - Each non-read pipeline slot drives pix_data=0, pix_valid=0.
- S_WRITE, in-range address: mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1, wr_ack=1, all for that one cycle.
- S_WRITE, out-of-range address: mem_we=0, wr_ack=1, wr_err=1, all for that one cycle.
- Writer protocol:
  - wr_addr and wr_data must be held stable while wr_req=1 and no wr_ack.
  - The writer may drop wr_req or present a new request in the cycle after wr_ack.
  - Back-to-back writes in consecutive free cycles are allowed: at most one ack per cycle, one write per ack.
- Simultaneous slot and wr_req: the read wins and wr_ack stays 0; the write waits with no limit. Starvation is bounded in practice by blanking (>=160 free cycles per line).
- S_IDLE: mem_we=0; mem_addr holds its last value.
- frame_done: pulses 1 cycle, in the cycle after the read of address H_ACTIVE*V_ACTIVE-1 is issued.
- Mid-frame reset: counter returns to 0. Fetching resumes correctly only from the next x==0 && y==0 slot; pixels before that may be misaddressed. Accepted.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE/V_ACTIVE and porch constants (common with the sync generator).
  - FRAME_PIXELS = H_ACTIVE*V_ACTIVE.
  - Grant-state encoding S_IDLE/S_READ/S_WRITE.
- One natural sub-module: scan_addr_counter (rd_cnt with increment, resync-to-0 and wrap, plus the frame_done pulse).
- Grant FSM and read pipeline stay in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with wr_req=1 -> wr_ack=0, mem_we=0, pix_valid=0, all outputs 0. Release -> write served in the first non-slot cycle.
- Scan-out: RAM preloaded with data=addr[7:0]. Drive slot at x=5,y=0 -> pix_data=5 two cycles later. First pixel of line 1 (x=0,y=1) -> pix_data=640&255=128.
- Contention: wr_req=1, wr_addr=100, wr_data=8'hAA asserted mid-line -> no ack while the slot is active. At x=H_ACTIVE: mem_we=1, mem_addr=100, wr_ack=1 same cycle. Read-back shows 8'hAA at 100.
- Back-to-back: 4 requests, one per ack, in blanking -> 4 consecutive cycles with mem_we=1, 4 wr_ack pulses, no gaps.
- Range: wr_addr=307200 -> wr_ack=1, wr_err=1, mem_we=0. wr_addr=307199 -> write performed, wr_err=0.
- Frame wrap: run a full frame -> frame_done pulses once, one cycle after the read of address 307199. The next frame's x=0,y=0 read uses mem_addr=0.
